// File: rtl/sub16_nibble_serial.sv
// Nibble-serial 16-bit subtractor: D = X - Y - Bi, one 4-bit slice per cycle over four cycles.
// Define SUB16_FLAGS_EN to add the registered Z (zero) and LT (signed less-than) flag outputs.
module sub16_nibble_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Bi,
  output logic [15:0] D,
  output logic        Bo,
  output logic        out_valid,
  input  logic        out_ready
`ifdef SUB16_FLAGS_EN
  ,
  output logic        Z,
  output logic        LT
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] d_q, d_d;
  logic        b_q, b_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [3:0]  x_nib;
  logic [3:0]  y_nib;
  logic [4:0]  slice;
  logic [15:0] d_slice;

  // The single 4-bit slice: X + ~Y + ~b, so carry-out is the inverted borrow.
  always_comb begin
    x_nib   = x_q[{cnt_q, 2'b00} +: 4];
    y_nib   = y_q[{cnt_q, 2'b00} +: 4];
    slice   = {1'b0, x_nib} + {1'b0, ~y_nib} + {4'b0000, ~b_q};
    d_slice = d_q;
    d_slice[{cnt_q, 2'b00} +: 4] = slice[3:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = X;
          y_d     = Y;
          b_d     = Bi;
          d_d     = 16'h0000;
          cnt_d   = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        d_d   = d_slice;
        b_d   = ~slice[4];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= 16'h0000;
      y_q     <= 16'h0000;
      d_q     <= 16'h0000;
      b_q     <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign Bo        = b_q;

`ifdef SUB16_FLAGS_EN
  logic z_q, z_d;
  logic lt_q, lt_d;
  logic ovf;

  // Flags are resolved on the last slice so they are registered alongside the final nibble.
  always_comb begin
    z_d  = z_q;
    lt_d = lt_q;
    ovf  = (x_q[15] != y_q[15]) && (d_slice[15] != x_q[15]);
    if (state_q == IDLE && in_valid) begin
      z_d  = 1'b0;
      lt_d = 1'b0;
    end else if (state_q == CALC && cnt_q == 2'd3) begin
      z_d  = (d_slice == 16'h0000);
      lt_d = d_slice[15] ^ ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q  <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      z_q  <= z_d;
      lt_q <= lt_d;
    end
  end

  assign Z  = z_q;
  assign LT = lt_q;
`endif

endmodule

// File: tb/tb_sub16_nibble_serial.sv
// Scoreboard bench for sub16_nibble_serial: stimulus pushes hand-computed results, a monitor pops
// and compares them on every output handshake.
module tb_sub16_nibble_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] X;
  logic [15:0] Y;
  logic        Bi;
  logic [15:0] D;
  logic        Bo;
  logic        out_valid;
  logic        out_ready;
`ifdef SUB16_FLAGS_EN
  logic        Z;
  logic        LT;
`endif

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        z;
    logic        lt;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  sub16_nibble_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .Bi        (Bi),
    .D         (D),
    .Bo        (Bo),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SUB16_FLAGS_EN
    ,
    .Z         (Z),
    .LT        (LT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = scoreboard.pop_front();
        checkOutput("D", {16'h0, D}, {16'h0, e.d});
        checkOutput("Bo", {31'h0, Bo}, {31'h0, e.bo});
`ifdef SUB16_FLAGS_EN
        checkOutput("Z", {31'h0, Z}, {31'h0, e.z});
        checkOutput("LT", {31'h0, LT}, {31'h0, e.lt});
`endif
      end
    end
  end

  // Issues one operand set, pushes its expected result, and returns just after the accept edge.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic bi,
                               input logic [15:0] ed, input logic ebo, input logic ez,
                               input logic elt);
    bit accepted;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    X  = x;
    Y  = y;
    Bi = bi;
    e.d = ed; e.bo = ebo; e.z = ez; e.lt = elt;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      scoreboard.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrained();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (scoreboard.size() == 0 && in_ready) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X  = 16'h0;
    Y  = 16'h0;
    Bi = 1'b0;
    #12;
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("reset_D", {16'h0, D}, 32'h0);
    checkOutput("reset_Bo", {31'h0, Bo}, 32'd0);
`ifdef SUB16_FLAGS_EN
    checkOutput("reset_Z", {31'h0, Z}, 32'd0);
    checkOutput("reset_LT", {31'h0, LT}, 32'd0);
`endif
    rst_n = 1'b1;

    $display("[TB] basic subtract and latency");
    applyStimulus(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("latency_out_valid", {31'h0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
    end
    waitDrained();

    $display("[TB] borrow chains and zero results");
    applyStimulus(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    waitDrained();

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(16'h00FF, 16'h0101, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    in_valid = 1'b1;
    X  = 16'h7FFF;
    Y  = 16'hFFFF;
    Bi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", {31'h0, out_valid}, 32'd1);
      checkOutput("stall_D", {16'h0, D}, 32'hFFFE);
      checkOutput("stall_Bo", {31'h0, Bo}, 32'd1);
      checkOutput("stall_in_ready", {31'h0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    begin
      exp_t e;
      e.d = 16'h8000; e.bo = 1'b1; e.z = 1'b0; e.lt = 1'b0;
      scoreboard.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("release_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("release_out_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDrained();

    $display("[TB] operand isolation");
    applyStimulus(16'h4321, 16'h1234, 1'b1, 16'h30EC, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      X  = 16'($urandom);
      Y  = 16'($urandom);
      Bi = 1'($urandom);
      @(posedge clk);
      #1;
    end
    waitDrained();

    $display("[TB] reset mid-operation");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    scoreboard.delete();
    #1;
    checkOutput("midreset_out_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("midreset_D", {16'h0, D}, 32'h0);
    checkOutput("midreset_Bo", {31'h0, Bo}, 32'd0);
    checkOutput("midreset_in_ready", {31'h0, in_ready}, 32'd1);
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_reset_out_valid", {31'h0, out_valid}, 32'd0);
    end
    applyStimulus(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    waitDrained();

    checkOutput("scoreboard_empty", scoreboard.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
